tick_mod_counter: RTL and testbench



---
 rtl/tick_pkg.sv | 61 ++++++
 rtl/tick_sync_edge.sv | 62 ++++++
 rtl/tick_mod_counter.sv | 120 ++++++++++++
 tb/tb_tick_mod_counter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tick_pkg.sv
// Shared definitions for tick_mod_counter:
//   - ARM/RUN state type for the tick synchroniser
//   - seven-segment pattern table (active-low, {g,f,e,d,c,b,a})
//   - parameter legality limits and check function
package tick_pkg;

    typedef enum logic {
        ST_ARM = 1'b0,
        ST_RUN = 1'b1
    } tick_state_e;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int MOD_MIN         = 2;
    localparam int W_MAX           = 30;

    // Arm counter must hold SYNC_STAGES_MAX.
    localparam int ARM_CNT_W = 3;

    // Active-low hex digit patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG7_LUT [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    // True when the counter configuration is within its supported range.
    function automatic logic cfg_legal(input int mod, input int w, input int sync);
        logic ok;
        ok = 1'b1;
        if ((w < 1) || (w > W_MAX)) begin
            ok = 1'b0;
        end else if ((mod < MOD_MIN) || (64'(mod) > (64'd1 << w))) begin
            ok = 1'b0;
        end else if ((sync < SYNC_STAGES_MIN) || (sync > SYNC_STAGES_MAX)) begin
            ok = 1'b0;
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

    // Hex nibble to active-low segment pattern.
    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        return SEG7_LUT[nib];
    endfunction

endpackage

// File: rtl/tick_sync_edge.sv
// Brings the asynchronous divider output into the fin domain, detects its
// rising edges and gates them with an ARM/RUN state so that a tick level
// already high when reset releases is never mistaken for an edge.
module tick_sync_edge
    import tick_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic fin,
    input  logic rst_n,
    input  logic tick_i,
    output logic step_o
);

    localparam logic [ARM_CNT_W-1:0] ARM_LAST = ARM_CNT_W'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    tick_state_e            state_q;
    logic [ARM_CNT_W-1:0]   arm_cnt_q;
    logic                   rise_s;

    // Synchroniser chain plus the previous-value flop used for edge detection.
    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // ARM holds for SYNC_STAGES+1 cycles after reset so the chain can flush.
    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ARM;
            arm_cnt_q <= {ARM_CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_ARM: begin
                    if (arm_cnt_q == ARM_LAST) begin
                        state_q <= ST_RUN;
                    end else begin
                        arm_cnt_q <= arm_cnt_q + {{(ARM_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q   <= ST_ARM;
                    arm_cnt_q <= {ARM_CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign rise_s = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign step_o = rise_s & (state_q == ST_RUN);

endmodule

// File: rtl/tick_mod_counter.sv
// Modulo-MOD up/down counter advanced by rising edges of an asynchronous
// tick input, with synchronous load and a one-cycle wrap carry.
// Optional build macro TICK_MOD_COUNTER_SEG7_EN adds a registered,
// active-low seven-segment decode of the low nibble of count on port seg.
module tick_mod_counter
    import tick_pkg::*;
#(
    parameter int MOD         = 10,
    parameter int W           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         fin,
    input  logic         rst_n,
    input  logic         tick_in,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
`ifdef TICK_MOD_COUNTER_SEG7_EN
    output logic [6:0]   seg,
`endif
    output logic         carry
);

    // Wrap compare uses MOD-1 so MOD == 2^W needs no extra bit.
    localparam logic [W-1:0] MOD_MAX = W'(MOD - 1);
    localparam logic [W-1:0] ZERO    = {W{1'b0}};
    localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

    if (!cfg_legal(MOD, W, SYNC_STAGES)) begin : g_bad_cfg
        $error("tick_mod_counter: illegal MOD/W/SYNC_STAGES combination");
    end

    logic         step_s;
    logic         load_ok_s;
    logic [W-1:0] count_d;
    logic [W-1:0] count_q;
    logic         carry_d;
    logic         carry_q;

    tick_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .fin    (fin),
        .rst_n  (rst_n),
        .tick_i (tick_in),
        .step_o (step_s)
    );

    assign load_ok_s = (32'(load_val) < MOD);

    // Next count/carry: load beats step; a step with en low is dropped.
    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        if (load) begin
            count_d = load_ok_s ? load_val : ZERO;
            carry_d = 1'b0;
        end else if (step_s && en) begin
            if (up) begin
                if (count_q == MOD_MAX) begin
                    count_d = ZERO;
                    carry_d = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                    carry_d = 1'b0;
                end
            end else begin
                if (count_q == ZERO) begin
                    count_d = MOD_MAX;
                    carry_d = 1'b1;
                end else begin
                    count_d = count_q - ONE;
                    carry_d = 1'b0;
                end
            end
        end else begin
            count_d = count_q;
            carry_d = 1'b0;
        end
    end

    // Count and carry registers; carry lands with the wrapped value.
    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= ZERO;
            carry_q <= 1'b0;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
        end
    end

    assign count = count_q;
    assign carry = carry_q;

`ifdef TICK_MOD_COUNTER_SEG7_EN
    logic [3:0] nib_s;
    logic [6:0] seg_q;

    if (W >= 4) begin : g_nib_wide
        assign nib_s = count_q[3:0];
    end else begin : g_nib_narrow
        assign nib_s = {{(4-W){1'b0}}, count_q};
    end

    // Segment register trails count by one cycle.
    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 7'b1000000;
        end else begin
            seg_q <= seg7_decode(nib_s);
        end
    end

    assign seg = seg_q;
`endif

endmodule

// File: tb/tb_tick_mod_counter.sv
// Scoreboard bench for tick_mod_counter (MOD=10, W=4, SYNC_STAGES=2).
// Expected count/carry values are pushed with the cycle they are due when a
// tick or load is driven; a negedge monitor pops and compares them.
module tb_tick_mod_counter;

    localparam int MOD = 10;
    localparam int W   = 4;

    logic         fin;
    logic         rst_n;
    logic         tick_in;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         carry;
`ifdef TICK_MOD_COUNTER_SEG7_EN
    logic [6:0]   seg;
`endif

    typedef struct {
        int         due;
        logic [3:0] cnt;
        logic       car;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    int         cyc;
    int         n_tests;
    int         n_fail;
    int         carry_seen;
    logic [3:0] m_count;

    tick_mod_counter #(
        .MOD(MOD), .W(W), .SYNC_STAGES(2)
    ) dut (
        .fin      (fin),
        .rst_n    (rst_n),
        .tick_in  (tick_in),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
`ifdef TICK_MOD_COUNTER_SEG7_EN
        .seg      (seg),
`endif
        .carry    (carry)
    );

    initial fin = 1'b0;
    always #5 fin = ~fin;

    // Posedge counter used to time expectations.
    always @(posedge fin) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input int due, input logic [3:0] c, input logic k, input string tag);
        exp_t e;
        e.due = due;
        e.cnt = c;
        e.car = k;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Scoreboard monitor.
    always @(negedge fin) begin
        exp_t e;
        if (carry === 1'b1) carry_seen++;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                check_val({e.tag, "_late"}, 32'(cyc), 32'(e.due));
            end else begin
                check_val({e.tag, "_count"}, 32'(count), 32'(e.cnt));
                check_val({e.tag, "_carry"}, 32'(carry), 32'(e.car));
            end
        end
    end

`ifdef TICK_MOD_COUNTER_SEG7_EN
    function automatic logic [6:0] seg_ref(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    logic [3:0] prev_cnt = 4'd0;
    // seg must show the decode of the count seen one cycle earlier.
    always @(negedge fin) begin
        check_val("seg", 32'(seg), 32'(seg_ref(prev_cnt)));
        prev_cnt <= count;
    end
`endif

    // One tick_in period; expectation due 3 edges after the negedge that raises tick_in.
    task automatic tick_pulse(input int hi, input int lo);
        int         k;
        logic [3:0] nc;
        logic       nk;
        @(negedge fin);
        k = cyc;
        tick_in = 1'b1;
        nk = 1'b0;
        if (!en) begin
            nc = m_count;
        end else if (up) begin
            if (m_count == 4'(MOD - 1)) begin nc = 4'd0; nk = 1'b1; end
            else nc = m_count + 4'd1;
        end else begin
            if (m_count == 4'd0) begin nc = 4'(MOD - 1); nk = 1'b1; end
            else nc = m_count - 4'd1;
        end
        push_exp(k + 2, m_count, 1'b0, "pre");
        push_exp(k + 3, nc, nk, "upd");
        push_exp(k + 4, nc, 1'b0, "post");
        m_count = nc;
        repeat (hi - 1) @(negedge fin);
        tick_in = 1'b0;
        repeat (lo) @(negedge fin);
    endtask

    task automatic do_load(input logic [3:0] v);
        int k;
        @(negedge fin);
        k = cyc;
        load = 1'b1;
        load_val = v;
        m_count = (int'(v) < MOD) ? v : 4'd0;
        push_exp(k + 1, m_count, 1'b0, "load");
        @(negedge fin);
        load = 1'b0;
    endtask

    task automatic do_reset(input logic tick_level);
        @(negedge fin);
        tick_in = tick_level;
        rst_n = 1'b0;
        #1;
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_carry", 32'(carry), 32'd0);
        repeat (3) @(negedge fin);
        rst_n = 1'b1;
        m_count = 4'd0;
    endtask

    initial begin
        int k;
        cyc = 0; n_tests = 0; n_fail = 0; carry_seen = 0;
        rst_n = 1'b0; tick_in = 1'b0; en = 1'b1; up = 1'b1;
        load = 1'b0; load_val = 4'd0; m_count = 4'd0;

        // Scenario 1: count up through a wrap.
        do_reset(1'b0);
        repeat (4) @(negedge fin);
        carry_seen = 0;
        for (int i = 0; i < 12; i++) tick_pulse(8, 8);
        check_val("s1_carry_pulses", 32'(carry_seen), 32'd1);

        // Scenario 2: tick high across reset release must not count.
        do_reset(1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge fin);
            check_val("s2_hold_count", 32'(count), 32'd0);
            check_val("s2_hold_carry", 32'(carry), 32'd0);
        end
        tick_in = 1'b0;
        repeat (8) @(negedge fin);
        tick_pulse(8, 8);

        // Scenario 3: down-count wraps from 0 to MOD-1.
        do_load(4'd0);
        up = 1'b0;
        carry_seen = 0;
        tick_pulse(8, 8);
        tick_pulse(8, 8);
        check_val("s3_carry_pulses", 32'(carry_seen), 32'd1);
        up = 1'b1;

        // Scenario 4: load coincident with step wins.
        @(negedge fin);
        k = cyc;
        tick_in = 1'b1;
        @(negedge fin);
        @(negedge fin);
        load = 1'b1;
        load_val = 4'd7;
        m_count = 4'd7;
        push_exp(k + 3, 4'd7, 1'b0, "s4_load");
        push_exp(k + 4, 4'd7, 1'b0, "s4_after");
        push_exp(k + 9, 4'd7, 1'b0, "s4_late");
        @(negedge fin);
        load = 1'b0;
        repeat (5) @(negedge fin);
        tick_in = 1'b0;
        repeat (8) @(negedge fin);

        // Scenario 5: out-of-range load clears; disabled steps are dropped.
        do_load(4'd12);
        en = 1'b0;
        for (int i = 0; i < 3; i++) tick_pulse(8, 8);
        en = 1'b1;
        tick_pulse(8, 8);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge fin);
        check_val("sb_drain", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
